// File: rtl/pamac_pkg.sv
// Shared types and clamp limits for the PAMAC accumulation lane.
package pamac_pkg;

  typedef enum logic [1:0] {IDLE, ACCUM, RESULT} state_t;

  localparam logic [31:0] ACC_MAX = 32'h7FFFFFFF;
  localparam logic [31:0] ACC_MIN = 32'h80000000;
  localparam logic [23:0] OUT_MAX = 24'h7FFFFF;
  localparam logic [23:0] OUT_MIN = 24'h800000;

endpackage

// File: rtl/saturate_32_to_24.sv
// Combinational signed 32-to-24-bit saturator; sat flags a clamped value.
module saturate_32_to_24
  import pamac_pkg::*;
(
  input  logic [31:0] din,
  output logic [23:0] dout,
  output logic        sat
);

  // Representable iff the top 9 bits are a pure sign extension.
  logic in_range;
  assign in_range = (&din[31:23]) | ~(|din[31:23]);

  always_comb begin
    dout = din[23:0];
    sat  = 1'b0;
    if (!in_range) begin
      dout = din[31] ? OUT_MIN : OUT_MAX;
      sat  = 1'b1;
    end
  end

endmodule

// File: rtl/pamac_acc_sched.sv
// Job sequencer for one PAMAC lane: clamped 32-bit accumulate, 24-bit
// saturated result on a valid/ready port, sticky saturation-event counter.
module pamac_acc_sched
  import pamac_pkg::*;
#(
  parameter int IN_W  = 32,
  parameter int OUT_W = 24,
  parameter int LEN_W = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic [IN_W-1:0]  cfg_bias,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_sat,
  output logic             busy,
  input  logic             sat_clr,
  output logic [CNT_W-1:0] sat_count
);

  state_t           state;
  logic [IN_W-1:0]  acc, sum, acc_nxt;
  logic [LEN_W-1:0] rem;
  logic             acc_clamped, ovf, range_sat;
  logic [OUT_W-1:0] sat_data;
  logic             beat, xfer;

  assign in_ready = (state == ACCUM);
  assign busy     = (state != IDLE);
  assign beat     = in_valid & in_ready;
  assign xfer     = out_valid & out_ready;

  // In IDLE the saturator sees the bias so a zero-length job can finish directly.
  always_comb begin
    sum     = acc + in_data;
    ovf     = (acc[IN_W-1] == in_data[IN_W-1]) && (sum[IN_W-1] != acc[IN_W-1]);
    acc_nxt = sum;
    if (state == IDLE)
      acc_nxt = cfg_bias;
    else if (ovf)
      acc_nxt = acc[IN_W-1] ? ACC_MIN : ACC_MAX;
  end

  saturate_32_to_24 u_sat (
    .din  (acc_nxt),
    .dout (sat_data),
    .sat  (range_sat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      acc         <= '0;
      rem         <= '0;
      acc_clamped <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_sat     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          acc         <= cfg_bias;
          rem         <= cfg_len;
          acc_clamped <= 1'b0;
          if (cfg_len == '0) begin
            state     <= RESULT;
            out_data  <= sat_data;
            out_sat   <= range_sat;
            out_valid <= 1'b1;
          end else begin
            state <= ACCUM;
          end
        end
        ACCUM: if (beat) begin
          acc <= acc_nxt;
          rem <= rem - 1'b1;
          if (ovf) acc_clamped <= 1'b1;
          if (rem == LEN_W'(1)) begin
            state     <= RESULT;
            out_data  <= sat_data;
            out_sat   <= acc_clamped | ovf | range_sat;
            out_valid <= 1'b1;
          end
        end
        RESULT: if (out_ready) begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      sat_count <= '0;
    else if (sat_clr)
      sat_count <= '0;
    else if (xfer && out_sat && !(&sat_count))
      sat_count <= sat_count + 1'b1;
  end

endmodule
